laser_score: RTL and testbench

Scoring monitor placed directly downstream of the laser-treatment solver. It snoops the same 40-point X/Y stream the solver consumes and, when the solver pulses DONE, latches the two reported circle centres. It then re-evaluates every stored point against both circles (radius 4) and reports the per-circle and union coverage counts. The bench uses it as an on-chip checker, and the top level uses it as a quality readout.

---
 rtl/laser_score.sv | 133 +++++++++++++
 tb/tb_laser_score.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/laser_score.sv
// laser_score: re-scores the solver's 40-point frame against its two reported
// circles (radius 4), evaluating in place while the next frame streams in.
module laser_score (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic [5:0] CNT1,
  output logic [5:0] CNT2,
  output logic [5:0] CNT_U,
  output logic       SCORE_VALID
);

  typedef enum logic [1:0] {
    S_FILL,
    S_FULL,
    S_EVAL
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_idx;
  logic [7:0] r_buf [40];
  logic [3:0] r_c1x, r_c1y, r_c2x, r_c2y;
  logic [5:0] r_acc1, r_acc2, r_accu;

  logic       w_last;
  logic       w_wr;
  logic [5:0] w_rd_idx;
  logic [7:0] w_pt;
  logic       w_cov1, w_cov2, w_covu;

  function automatic logic covered(
    input logic [3:0] px,
    input logic [3:0] py,
    input logic [3:0] cx,
    input logic [3:0] cy
  );
    logic [3:0] dx;
    logic [3:0] dy;
    logic [8:0] s;
    dx = (px >= cx) ? px - cx : cx - px;
    dy = (py >= cy) ? py - cy : cy - py;
    s  = 9'(dx) * 9'(dx) + 9'(dy) * 9'(dy);
    return s <= 9'd16;
  endfunction

  assign w_last   = (r_idx == 6'd39);
  assign w_rd_idx = (r_idx < 6'd40) ? r_idx : 6'd0;
  assign w_pt     = r_buf[w_rd_idx];
  assign w_cov1   = covered(w_pt[7:4], w_pt[3:0], r_c1x, r_c1y);
  assign w_cov2   = covered(w_pt[7:4], w_pt[3:0], r_c2x, r_c2y);
  assign w_covu   = w_cov1 | w_cov2;

  // EVAL reads slot idx above and overwrites it with the new point here.
  assign w_wr = !RST &&
                (((r_state == S_FILL) && !DONE) ||
                 (r_state == S_EVAL));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FILL:  if (!DONE && w_last) w_next = S_FULL;
      S_FULL:  if (DONE) w_next = S_EVAL;
      S_EVAL:  if (w_last) w_next = S_FULL;
      default: w_next = S_FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FILL;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_buf[w_rd_idx] <= {X, Y};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx       <= 6'd0;
      r_acc1      <= 6'd0;
      r_acc2      <= 6'd0;
      r_accu      <= 6'd0;
      CNT1        <= 6'd0;
      CNT2        <= 6'd0;
      CNT_U       <= 6'd0;
      SCORE_VALID <= 1'b0;
    end else begin
      SCORE_VALID <= 1'b0;
      unique case (r_state)
        S_FILL: begin
          if (DONE)        r_idx <= 6'd0;
          else if (w_last) r_idx <= 6'd40;
          else             r_idx <= r_idx + 6'd1;
        end
        S_FULL: begin
          if (DONE) begin
            r_c1x  <= C1X;
            r_c1y  <= C1Y;
            r_c2x  <= C2X;
            r_c2y  <= C2Y;
            r_acc1 <= 6'd0;
            r_acc2 <= 6'd0;
            r_accu <= 6'd0;
            r_idx  <= 6'd0;
          end
        end
        S_EVAL: begin
          r_acc1 <= r_acc1 + {5'd0, w_cov1};
          r_acc2 <= r_acc2 + {5'd0, w_cov2};
          r_accu <= r_accu + {5'd0, w_covu};
          if (w_last) begin
            CNT1        <= r_acc1 + {5'd0, w_cov1};
            CNT2        <= r_acc2 + {5'd0, w_cov2};
            CNT_U       <= r_accu + {5'd0, w_covu};
            SCORE_VALID <= 1'b1;
            r_idx       <= 6'd40;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        default: r_idx <= 6'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_score.sv
// tb_laser_score: scoreboard bench; expected counts queued at DONE,
// compared against each SCORE_VALID pulse.
module tb_laser_score;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] X, Y, C1X, C1Y, C2X, C2Y;
  logic       DONE;
  logic [5:0] CNT1, CNT2, CNT_U;
  logic       SCORE_VALID;

  laser_score dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .CNT1(CNT1), .CNT2(CNT2), .CNT_U(CNT_U),
    .SCORE_VALID(SCORE_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int c1;
    int c2;
    int cu;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   cur_x[40], cur_y[40];
  int   nxt_x[40], nxt_y[40];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cov(input int px, py, cx, cy);
    return ((px - cx) * (px - cx) + (py - cy) * (py - cy)) <= 16;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (SCORE_VALID) begin
      if (q.size() == 0) begin
        chk("spurious_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("cnt1", int'(CNT1), e.c1);
        chk("cnt2", int'(CNT2), e.c2);
        chk("cnt_u", int'(CNT_U), e.cu);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int x, input int y, input logic d);
    X    = 4'(x);
    Y    = 4'(y);
    DONE = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_cur();
    for (int k = 0; k < 40; k++) step(cur_x[k], cur_y[k], 1'b0);
  endtask

  // DONE edge in FULL, then 40 EVAL cycles streaming nxt into the buffer.
  task automatic score(input int a, b, c, d,
                       input int inj_at, input int rst_at);
    exp_t e;
    e.c1 = 0; e.c2 = 0; e.cu = 0;
    for (int k = 0; k < 40; k++) begin
      int p, r;
      p = cov(cur_x[k], cur_y[k], a, b);
      r = cov(cur_x[k], cur_y[k], c, d);
      e.c1 += p;
      e.c2 += r;
      e.cu += (p | r);
    end
    e.cyc = cyc + 41;
    q.push_back(e);
    C1X = 4'(a); C1Y = 4'(b); C2X = 4'(c); C2Y = 4'(d);
    step(0, 0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      if (k == rst_at) begin
        RST = 1'b1;
        step(nxt_x[k], nxt_y[k], 1'b0);
        RST = 1'b0;
        chk("abort_cnt1", int'(CNT1), 0);
        chk("abort_cnt2", int'(CNT2), 0);
        chk("abort_cnt_u", int'(CNT_U), 0);
        chk("abort_valid", int'(SCORE_VALID), 0);
        void'(q.pop_back());
        return;
      end
      if (k == inj_at) begin
        C1X = 4'd15; C1Y = 4'd15; C2X = 4'd15; C2Y = 4'd15;
      end
      step(nxt_x[k], nxt_y[k], k == inj_at);
    end
    cur_x = nxt_x;
    cur_y = nxt_y;
  endtask

  task automatic rand_nxt();
    for (int k = 0; k < 40; k++) begin
      nxt_x[k] = $urandom_range(3, 12);
      nxt_y[k] = $urandom_range(3, 12);
    end
  endtask

  initial begin
    RST = 1'b1; DONE = 1'b0; X = 0; Y = 0;
    C1X = 0; C1Y = 0; C2X = 0; C2Y = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cnt1", int'(CNT1), 0);
    chk("rst_cnt2", int'(CNT2), 0);
    chk("rst_cnt_u", int'(CNT_U), 0);
    chk("rst_valid", int'(SCORE_VALID), 0);
    RST = 1'b0;

    for (int k = 0; k < 40; k++) begin cur_x[k] = 8; cur_y[k] = 8; end
    fill_cur();

    for (int k = 0; k < 40; k++) begin nxt_x[k] = 15; nxt_y[k] = 15; end
    nxt_x[0] = 4; nxt_y[0] = 0;
    nxt_x[1] = 0; nxt_y[1] = 4;
    nxt_x[2] = 3; nxt_y[2] = 3;
    nxt_x[3] = 4; nxt_y[3] = 1;
    score(8, 8, 0, 0, -1, -1);

    for (int k = 0; k < 40; k++) begin
      nxt_x[k] = (k < 20) ? 5 : 10;
      nxt_y[k] = (k < 20) ? 5 : 10;
    end
    score(0, 0, 0, 0, 20, -1);

    rand_nxt();
    score(5, 5, 7, 7, -1, -1);

    rand_nxt();
    score(7, 8, 9, 6, -1, 15);

    rand_nxt();
    cur_x = nxt_x; cur_y = nxt_y;
    fill_cur();
    rand_nxt();
    score(6, 6, 10, 9, -1, -1);
    rand_nxt();
    score(8, 5, 5, 10, -1, -1);

    RST = 1'b1;
    step(0, 0, 1'b0);
    RST = 1'b0;
    for (int k = 0; k < 10; k++) step(1, 1, 1'b0);
    step(0, 0, 1'b1);
    rand_nxt();
    cur_x = nxt_x; cur_y = nxt_y;
    fill_cur();
    rand_nxt();
    score(9, 9, 4, 7, -1, -1);

    repeat (4) step(0, 0, 1'b0);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
